pea_tile_seq: RTL and testbench
===============================

# pea_tile_seq

Parametrised tile sequencer for the PE array; successor to the 3x3 controller. Adds a 1x1/3x3 kernel mode and configuration latched at start. Adds downstream backpressure (`stall`), exact-length last column tiles (no padded cycles), a drain phase and `busy`/`done` status. Drives IFM/weight buffer read strobes and per-row pixel-valid to the PE array, and sequences pixel → input channel → output channel → tile column → tile row.

## Interface
- `COL`, 8: PE rows, i.e. output rows per tile; width of `pvalid`.
- `TILE_LEN`, 16: output pixels per tile column pass.
- `CHN_WIDTH`, 4: width of `chi`/`cho` (channel count in units of 2^CHN_OFT_WIDTH).
- `CHN_OFT_WIDTH`, 6: log2 of channels per `chi`/`cho` unit.
- `FMS_WIDTH`, 8: feature-map size width.
- `FLUSH_DEPTH`, 5: PE pipeline fill cycles before each calc pass (≥2).
- `VLD_LAT`, 3: cycles from calc cycle to its `pvalid`.
- `clk` in 1: the single clock.
- `rstn` in 1: asynchronous, active-low reset.
- `start` in 1: pulse; accepted only in IDLE.
- `chi`, `cho` in CHN_WIDTH: input/output channel units.
- `stride` in 1: 0 = stride 1, 1 = stride 2.
- `ksize` in 1: 0 = 1x1, 1 = 3x3.
- `ifm_size` in FMS_WIDTH: IFM size including padding.
- `group` in 1: depthwise; one ic pass per oc.
- `stall` in 1: downstream backpressure.
- `ifm_read`, `wgt_read` out 1: buffer read strobes.
- `pvalid` out COL: per-row output-pixel valid.
- `ic_done`, `oc_done`, `tile_done`, `conv_done` out 1: loop-end pulses.
- `busy`, `done` out 1: status; `done` is a single-cycle pulse.

## Operation
- Config is latched on accepted `start`. Config input changes while `busy` have no effect.
- ofm (FMS_WIDTH, truncating):
  - 3x3: s1 = ifm−2; s2 = ((ifm−3)>>1)+1.
  - 1x1: s1 = ifm; s2 = ((ifm−1)>>1)+1.
  - Constraint: ofm ≥ 1.
- Tile counts:
  - tc_col_max = ceil(ofm/TILE_LEN)−1; tc_row_max = ceil(ofm/COL)−1.
  - col_len = ofm mod TILE_LEN on the last column tile if nonzero, else TILE_LEN.
  - row_len = ofm mod COL on the last row tile if nonzero, else COL.
- Loop limits: ic_num = (chi<<CHN_OFT_WIDTH)−1, forced to 0 when `group`; oc_num = (cho<<CHN_OFT_WIDTH)−1. Both are CHN_WIDTH+CHN_OFT_WIDTH wide.
- FSM states:
  - IDLE → FLUSH on `start`.
  - FLUSH → CALC after FLUSH_DEPTH advancing cycles.
  - CALC → FLUSH on `ic_done` without `conv_done`; CALC → DRAIN on `conv_done`.
  - DRAIN → IDLE after VLD_LAT cycles.
- Advancing cycle = any cycle with `stall`=0. While `stall`=1, state, flush counter, pixel/phase, ic/oc/tile counters all hold.
- CALC pass:
  - Pixel counter runs 0..col_len−1.
  - s1: advances every advancing cycle.
  - s2: a phase bit toggles each advancing cycle; the pixel advances when phase=1. A pass is therefore 2·col_len advancing cycles.
- Pulses, combinational, qualified by advancing:
  - `ic_done` on the last advancing cycle of a pass.
  - `oc_done` = `ic_done` & ic last.
  - `tile_done` = `oc_done` & oc last.
  - `conv_done` = `tile_done` & last col & last row.
- Counter updates on `ic_done`: ic wraps on `oc_done`; oc wraps on `tile_done`; tile col wraps to 0 at the end of a row; tile row clears at `conv_done`.
- Read strobes:
  - `ifm_read` = (`start`&IDLE | FLUSH | CALC) & !`stall`.
  - `wgt_read` = (`start`&IDLE | first 2 advancing cycles of each FLUSH) & !`stall`.
- `pvalid`:
  - Source = CALC & advancing & (s1 | phase=1), delayed VLD_LAT cycles by a shift pipeline.
  - The pipeline is not stalled; stalled cycles inject 0.
  - Row mask is delayed identically: (1<<row_len)−1 on the last row tile, else all ones.
- `busy` is high from the cycle after accepted `start` until IDLE re-entry. `done` pulses on the final DRAIN cycle.
- `start` while `busy` is ignored.

## Timing
- Reset values:
  - FSM = IDLE; all counters, phase, flush counter, pipeline = 0.
  - All outputs 0: `pvalid`=0, `busy`=0, `done`=0.
- Reset is asynchronous: asserting `rstn` mid-run clears everything immediately. No residual `pvalid` after release.
- `start` at cycle t: FLUSH at t+1. First CALC at t+1+FLUSH_DEPTH when no stall.
- `pvalid` for a calc cycle at t appears at t+VLD_LAT.
- `conv_done` at t: DRAIN t+1..t+VLD_LAT; `done` at t+VLD_LAT; IDLE at t+VLD_LAT+1.
- A new `start` is accepted at t+VLD_LAT+1.
- `stall` asserted in the same cycle as the would-be `ic_done` suppresses `ic_done`; it fires on the next advancing cycle.

## Test plan
- **Reset:** `rstn`=0 then release, no `start` → all outputs 0 for 100 cycles. `rstn` pulsed low mid-CALC → outputs 0 in the same cycle; a fresh `start` then completes normally.
- **3x3 s1, ifm=18, chi=1, cho=1, group=1:** ofm=16, 1 col × 2 row tiles. Expect 128 `ic_done`, `pvalid`=8'hFF on 2048 cycles, 1 `conv_done`, `done` 3 cycles later.
- **3x3 s1, ifm=22, group=1, cho=1:** ofm=20. Col passes are 16 then 4 cycles. Row tiles are 3; the last has `pvalid`=8'h0F. Total pvalid-bit count = 64·20·20.
- **3x3 s2, ifm=35, group=1, cho=1:** ofm=17. `pvalid` asserts on alternate cycles. The last col pass is 2 cycles. The last row tile has `pvalid`=8'h01.
- **1x1 s1, ifm=8, chi=2, cho=1, group=0:** ofm=8. Expect 128 `ic_done` per oc and 64 `oc_done`. `wgt_read` count = 2·(number of FLUSH entries) + 1.
- **stall:** `stall` high for 7 cycles mid-CALC in the ifm=18 case → pixel counter holds, `ifm_read`=0, 7-cycle `pvalid` gap, `conv_done` delayed exactly 7 cycles, total pvalid count unchanged. A `start` pulsed while `busy` → ignored.

Source files
------------

// File: rtl/pea_tile_seq.sv
// Tile sequencer for the PE array: walks pixel -> ic -> oc -> tile col -> tile row,
// drives IFM/weight read strobes and per-row pixel-valid, with stall, drain and status.
module pea_tile_seq #(
  parameter int COL           = 8,
  parameter int TILE_LEN      = 16,
  parameter int CHN_WIDTH     = 4,
  parameter int CHN_OFT_WIDTH = 6,
  parameter int FMS_WIDTH     = 8,
  parameter int FLUSH_DEPTH   = 5,
  parameter int VLD_LAT       = 3
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic [CHN_WIDTH-1:0] chi,
  input  logic [CHN_WIDTH-1:0] cho,
  input  logic                 stride,
  input  logic                 ksize,
  input  logic [FMS_WIDTH-1:0] ifm_size,
  input  logic                 group,
  input  logic                 stall,
  output logic                 ifm_read,
  output logic                 wgt_read,
  output logic [COL-1:0]       pvalid,
  output logic                 ic_done,
  output logic                 oc_done,
  output logic                 tile_done,
  output logic                 conv_done,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           dbg_state
);

  localparam int CW = CHN_WIDTH + CHN_OFT_WIDTH;
  localparam int PW = $clog2(TILE_LEN + 1);
  localparam int RW = $clog2(COL + 1);
  localparam int FW = $clog2(FLUSH_DEPTH + 1);
  localparam int DW = $clog2(VLD_LAT + 1);
  localparam logic [FMS_WIDTH-1:0] TILE_LEN_F = FMS_WIDTH'(TILE_LEN);
  localparam logic [FMS_WIDTH-1:0] COL_F      = FMS_WIDTH'(COL);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FLUSH = 2'd1,
    S_CALC  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  // Handshake: stall=1 freezes all sequencing state for that cycle (no advance);
  // the pvalid pipeline keeps shifting and receives 0 for the stalled cycle.

  state_t               state_q, state_d;
  logic [FW-1:0]        flush_q, flush_d;
  logic [DW-1:0]        drain_q, drain_d;
  logic [PW-1:0]        pix_q, pix_d;
  logic                 phase_q, phase_d;
  logic [CW-1:0]        ic_q, ic_d, oc_q, oc_d;
  logic [FMS_WIDTH-1:0] tcol_q, tcol_d, trow_q, trow_d;

  logic                 stride_q, stride_d;
  logic [CW-1:0]        ic_num_q, ic_num_d, oc_num_q, oc_num_d;
  logic [FMS_WIDTH-1:0] tc_col_max_q, tc_col_max_d, tc_row_max_q, tc_row_max_d;
  logic [PW-1:0]        col_last_len_q, col_last_len_d;
  logic [RW-1:0]        row_last_len_q, row_last_len_d;

  logic [VLD_LAT-1:0]          src_pipe_q, src_pipe_d;
  logic [VLD_LAT-1:0][COL-1:0] mask_pipe_q, mask_pipe_d;

  logic [FMS_WIDTH-1:0] ofm_c, col_rem_c, row_rem_c;
  logic [PW-1:0]        col_len;
  logic [COL-1:0]       row_mask;
  logic adv, accept, pix_last, pass_end, ic_last, oc_last, col_last, row_last, src_c;

  // Output geometry derived from the live inputs, captured only on accepted start.
  always_comb begin
    ofm_c = ifm_size;
    if (ksize) begin
      if (stride) ofm_c = ((ifm_size - FMS_WIDTH'(3)) >> 1) + FMS_WIDTH'(1);
      else        ofm_c = ifm_size - FMS_WIDTH'(2);
    end else if (stride) begin
      ofm_c = ((ifm_size - FMS_WIDTH'(1)) >> 1) + FMS_WIDTH'(1);
    end
    col_rem_c = ofm_c % TILE_LEN_F;
    row_rem_c = ofm_c % COL_F;
  end

  always_comb begin
    adv      = !stall;
    accept   = (state_q == S_IDLE) && start;
    col_last = (tcol_q == tc_col_max_q);
    row_last = (trow_q == tc_row_max_q);
    ic_last  = (ic_q == ic_num_q);
    oc_last  = (oc_q == oc_num_q);
    col_len  = col_last ? col_last_len_q : PW'(TILE_LEN);
    pix_last = (pix_q == col_len - PW'(1));
    pass_end = pix_last && (!stride_q || phase_q);

    ic_done   = (state_q == S_CALC) && adv && pass_end;
    oc_done   = ic_done && ic_last;
    tile_done = oc_done && oc_last;
    conv_done = tile_done && col_last && row_last;

    ifm_read  = (accept || (state_q == S_FLUSH) || (state_q == S_CALC)) && adv;
    wgt_read  = (accept || ((state_q == S_FLUSH) && (flush_q < FW'(2)))) && adv;
    done      = (state_q == S_DRAIN) && adv && (drain_q == DW'(VLD_LAT - 1));
    busy      = (state_q != S_IDLE);
    dbg_state = state_q;
    src_c     = (state_q == S_CALC) && adv && (!stride_q || phase_q);

    for (int i = 0; i < COL; i++) begin
      row_mask[i] = !row_last || (RW'(i) < row_last_len_q);
    end
  end

  always_comb begin
    state_d        = state_q;
    flush_d        = flush_q;
    drain_d        = drain_q;
    pix_d          = pix_q;
    phase_d        = phase_q;
    ic_d           = ic_q;
    oc_d           = oc_q;
    tcol_d         = tcol_q;
    trow_d         = trow_q;
    stride_d       = stride_q;
    ic_num_d       = ic_num_q;
    oc_num_d       = oc_num_q;
    tc_col_max_d   = tc_col_max_q;
    tc_row_max_d   = tc_row_max_q;
    col_last_len_d = col_last_len_q;
    row_last_len_d = row_last_len_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d        = S_FLUSH;
          flush_d        = '0;
          pix_d          = '0;
          phase_d        = 1'b0;
          ic_d           = '0;
          oc_d           = '0;
          tcol_d         = '0;
          trow_d         = '0;
          stride_d       = stride;
          ic_num_d       = group ? '0 : ({chi, {CHN_OFT_WIDTH{1'b0}}} - CW'(1));
          oc_num_d       = {cho, {CHN_OFT_WIDTH{1'b0}}} - CW'(1);
          tc_col_max_d   = (ofm_c - FMS_WIDTH'(1)) / TILE_LEN_F;
          tc_row_max_d   = (ofm_c - FMS_WIDTH'(1)) / COL_F;
          col_last_len_d = (col_rem_c == '0) ? PW'(TILE_LEN) : PW'(col_rem_c);
          row_last_len_d = (row_rem_c == '0) ? RW'(COL) : RW'(row_rem_c);
        end
      end
      S_FLUSH: begin
        if (adv) begin
          if (flush_q == FW'(FLUSH_DEPTH - 1)) begin
            state_d = S_CALC;
            flush_d = '0;
            pix_d   = '0;
            phase_d = 1'b0;
          end else begin
            flush_d = flush_q + FW'(1);
          end
        end
      end
      S_CALC: begin
        if (adv) begin
          // Stride 2 spends two cycles per output pixel; the pixel moves on phase 1.
          if (stride_q) begin
            phase_d = !phase_q;
            if (phase_q) pix_d = pix_q + PW'(1);
          end else begin
            pix_d = pix_q + PW'(1);
          end
          if (pass_end) begin
            pix_d   = '0;
            phase_d = 1'b0;
            drain_d = '0;
            state_d = conv_done ? S_DRAIN : S_FLUSH;
            ic_d    = ic_last ? '0 : ic_q + CW'(1);
            if (oc_done) oc_d = oc_last ? '0 : oc_q + CW'(1);
            if (tile_done) begin
              if (col_last) begin
                tcol_d = '0;
                trow_d = row_last ? '0 : trow_q + FMS_WIDTH'(1);
              end else begin
                tcol_d = tcol_q + FMS_WIDTH'(1);
              end
            end
          end
        end
      end
      S_DRAIN: begin
        if (adv) begin
          if (drain_q == DW'(VLD_LAT - 1)) begin
            state_d = S_IDLE;
            drain_d = '0;
          end else begin
            drain_d = drain_q + DW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Valid/mask delay line runs every cycle so stalled cycles appear as gaps.
  always_comb begin
    src_pipe_d     = src_pipe_q;
    mask_pipe_d    = mask_pipe_q;
    src_pipe_d[0]  = src_c;
    mask_pipe_d[0] = row_mask;
    for (int i = 1; i < VLD_LAT; i++) begin
      src_pipe_d[i]  = src_pipe_q[i-1];
      mask_pipe_d[i] = mask_pipe_q[i-1];
    end
    pvalid = src_pipe_q[VLD_LAT-1] ? mask_pipe_q[VLD_LAT-1] : '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= S_IDLE;
      flush_q        <= '0;
      drain_q        <= '0;
      pix_q          <= '0;
      phase_q        <= 1'b0;
      ic_q           <= '0;
      oc_q           <= '0;
      tcol_q         <= '0;
      trow_q         <= '0;
      stride_q       <= 1'b0;
      ic_num_q       <= '0;
      oc_num_q       <= '0;
      tc_col_max_q   <= '0;
      tc_row_max_q   <= '0;
      col_last_len_q <= '0;
      row_last_len_q <= '0;
      src_pipe_q     <= '0;
      mask_pipe_q    <= '0;
    end else begin
      state_q        <= state_d;
      flush_q        <= flush_d;
      drain_q        <= drain_d;
      pix_q          <= pix_d;
      phase_q        <= phase_d;
      ic_q           <= ic_d;
      oc_q           <= oc_d;
      tcol_q         <= tcol_d;
      trow_q         <= trow_d;
      stride_q       <= stride_d;
      ic_num_q       <= ic_num_d;
      oc_num_q       <= oc_num_d;
      tc_col_max_q   <= tc_col_max_d;
      tc_row_max_q   <= tc_row_max_d;
      col_last_len_q <= col_last_len_d;
      row_last_len_q <= row_last_len_d;
      src_pipe_q     <= src_pipe_d;
      mask_pipe_q    <= mask_pipe_d;
    end
  end

endmodule

// File: tb/tb_pea_tile_seq.sv
// Bench for pea_tile_seq: table of convolution jobs with expected totals, plus a
// loop-order model feeding pvalid and loop-end scoreboards, and reset sequences.
module tb_pea_tile_seq;

  localparam int COL = 8;
  localparam int TILE_LEN = 16;
  localparam int FLUSH_DEPTH = 5;
  localparam int VLD_LAT = 3;

  logic clk, rstn, start, stride, ksize, group, stall;
  logic [3:0] chi, cho;
  logic [7:0] ifm_size;
  logic ifm_read, wgt_read, ic_done, oc_done, tile_done, conv_done, busy, done;
  logic [COL-1:0] pvalid;
  logic [1:0] dbg_state;

  pea_tile_seq #(
    .COL(COL), .TILE_LEN(TILE_LEN), .CHN_WIDTH(4), .CHN_OFT_WIDTH(6),
    .FMS_WIDTH(8), .FLUSH_DEPTH(FLUSH_DEPTH), .VLD_LAT(VLD_LAT)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .chi(chi), .cho(cho),
    .stride(stride), .ksize(ksize), .ifm_size(ifm_size), .group(group),
    .stall(stall), .ifm_read(ifm_read), .wgt_read(wgt_read), .pvalid(pvalid),
    .ic_done(ic_done), .oc_done(oc_done), .tile_done(tile_done),
    .conv_done(conv_done), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int chi, cho, stride, ksize, ifm, grp;
    int exp_ic, exp_oc, exp_tile, exp_pv_bits, exp_pv_cyc;
    int stall_at, stall_len, busy_start_at;
  } case_t;

  case_t cases[6];

  logic [COL-1:0] exp_q[$];
  logic [2:0]     fl_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  // scoreboard monitor
  logic mon_en = 1'b0;
  int ic_cnt, oc_cnt, tile_cnt, conv_cnt, done_cnt, pv_bits, pv_cyc;
  int wgt_cnt, ifm_cnt, busy_cnt, stall_rd, first_pv, conv_cyc, done_cyc;
  logic [COL-1:0] pv_e;
  logic [2:0] fl_e;

  always @(negedge clk) begin
    if (mon_en) begin
      if (pvalid != '0) begin
        pv_cyc++;
        pv_bits += $countones(pvalid);
        if (first_pv < 0) first_pv = cyc;
        if (exp_q.size() == 0) check("pvalid_extra", pvalid, 0);
        else begin
          pv_e = exp_q.pop_front();
          check("pvalid", pvalid, pv_e);
        end
      end
      if (ic_done) begin
        ic_cnt++;
        if (fl_q.size() == 0) check("icdone_extra", 1, 0);
        else begin
          fl_e = fl_q.pop_front();
          check("loop_flags", {oc_done, tile_done, conv_done}, fl_e);
        end
      end
      if (oc_done) oc_cnt++;
      if (tile_done) tile_cnt++;
      if (conv_done) begin conv_cnt++; conv_cyc = cyc; end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (wgt_read) wgt_cnt++;
      if (ifm_read) ifm_cnt++;
      if (busy) busy_cnt++;
      if (stall && ifm_read) stall_rd++;
    end
  end

  // Independent loop-nest model: queues expected pvalid words and loop-end flags.
  task automatic build_model(input case_t c, output int passes, output int len_sum);
    int ofm, ncol, nrow, icn, ocn, rl, cl;
    logic [COL-1:0] m;
    if (c.ksize != 0) ofm = (c.stride != 0) ? ((c.ifm - 3) >> 1) + 1 : c.ifm - 2;
    else              ofm = (c.stride != 0) ? ((c.ifm - 1) >> 1) + 1 : c.ifm;
    ncol = (ofm + TILE_LEN - 1) / TILE_LEN;
    nrow = (ofm + COL - 1) / COL;
    icn = (c.grp != 0) ? 1 : c.chi * 64;
    ocn = c.cho * 64;
    passes = 0;
    len_sum = 0;
    for (int tr = 0; tr < nrow; tr++) begin
      rl = (tr == nrow - 1 && (ofm % COL) != 0) ? ofm % COL : COL;
      m = '0;
      for (int b = 0; b < rl; b++) m[b] = 1'b1;
      for (int tc = 0; tc < ncol; tc++) begin
        cl = (tc == ncol - 1 && (ofm % TILE_LEN) != 0) ? ofm % TILE_LEN : TILE_LEN;
        for (int oc = 0; oc < ocn; oc++) begin
          for (int ic = 0; ic < icn; ic++) begin
            passes++;
            len_sum += FLUSH_DEPTH + cl * ((c.stride != 0) ? 2 : 1);
            for (int p = 0; p < cl; p++) exp_q.push_back(m);
            fl_q.push_back({ic == icn - 1,
                            ic == icn - 1 && oc == ocn - 1,
                            ic == icn - 1 && oc == ocn - 1 && tc == ncol - 1 && tr == nrow - 1});
          end
        end
      end
    end
  endtask

  // driver
  task automatic drive_cfg(input case_t c);
    chi = 4'(c.chi); cho = 4'(c.cho);
    stride = 1'(c.stride); ksize = 1'(c.ksize);
    ifm_size = 8'(c.ifm); group = 1'(c.grp);
  endtask

  task automatic run_case(input int idx, input case_t c);
    int passes, len_sum, t0, k, exp_len;
    exp_q.delete();
    fl_q.delete();
    build_model(c, passes, len_sum);
    ic_cnt = 0; oc_cnt = 0; tile_cnt = 0; conv_cnt = 0; done_cnt = 0;
    pv_bits = 0; pv_cyc = 0; wgt_cnt = 0; ifm_cnt = 0; busy_cnt = 0;
    stall_rd = 0; first_pv = -1; conv_cyc = 0; done_cyc = 0;
    exp_len = len_sum + VLD_LAT + c.stall_len;
    @(posedge clk); #1;
    mon_en = 1'b1;
    drive_cfg(c);
    start = 1'b1;
    t0 = cyc;
    k = 0;
    while (done_cnt == 0 && k < exp_len + 50) begin
      @(posedge clk); #1;
      k = cyc - t0;
      start = (k == c.busy_start_at);
      stall = (c.stall_len > 0 && k >= c.stall_at && k < c.stall_at + c.stall_len);
      if (k == 1) begin
        chi = 4'($urandom_range(0, 15)); cho = 4'($urandom_range(0, 15));
        stride = 1'($urandom_range(0, 1)); ksize = 1'($urandom_range(0, 1));
        ifm_size = 8'($urandom_range(0, 255)); group = 1'($urandom_range(0, 1));
      end
    end
    start = 1'b0;
    stall = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    mon_en = 1'b0;
    $display("case %0d: passes=%0d ic_done=%0d pv_bits=%0d run=%0d", idx, passes, ic_cnt, pv_bits, done_cyc - t0);
    check("done_count", done_cnt, 1);
    check("conv_count", conv_cnt, 1);
    check("ic_done_count", ic_cnt, c.exp_ic);
    check("oc_done_count", oc_cnt, c.exp_oc);
    check("tile_done_count", tile_cnt, c.exp_tile);
    check("pvalid_bits", pv_bits, c.exp_pv_bits);
    check("pvalid_cycles", pv_cyc, c.exp_pv_cyc);
    check("pv_queue_left", exp_q.size(), 0);
    check("flag_queue_left", fl_q.size(), 0);
    check("done_latency", done_cyc - conv_cyc, VLD_LAT);
    check("run_length", done_cyc - t0, exp_len);
    check("first_pvalid", first_pv - t0, FLUSH_DEPTH + 1 + VLD_LAT + c.stride);
    check("wgt_read_count", wgt_cnt, 2 * passes + 1);
    check("ifm_read_count", ifm_cnt, 1 + len_sum);
    check("busy_cycles", busy_cnt, exp_len);
    check("read_in_stall", stall_rd, 0);
    check("end_state_idle", dbg_state, 0);
  endtask

  int bad;

  initial begin
    // chi cho s k ifm grp | ic oc tile pv_bits pv_cyc | stall_at len busy_start
    cases[0] = '{1, 1, 0, 1, 18, 1,  128,  128, 2, 16384,  2048,  -1, 0, -1};
    cases[1] = '{1, 1, 0, 1, 22, 1,  384,  384, 6, 25600,  3840,  -1, 0, -1};
    cases[2] = '{1, 1, 1, 1, 35, 1,  384,  384, 6, 18496,  3264,  -1, 0, -1};
    cases[3] = '{1, 1, 0, 0,  4, 0, 4096,   64, 1, 65536, 16384,  -1, 0, -1};
    cases[4] = '{1, 1, 1, 0,  5, 1,   64,   64, 1,   576,   192,  -1, 0, -1};
    cases[5] = '{1, 1, 0, 1, 18, 1,  128,  128, 2, 16384,  2048,  21, 7, 100};

    rstn = 1'b0; start = 1'b0; stall = 1'b0;
    chi = '0; cho = '0; stride = 1'b0; ksize = 1'b0; ifm_size = '0; group = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    // idle after reset
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (pvalid != '0 || busy || done || ifm_read || wgt_read ||
          ic_done || oc_done || tile_done || conv_done) bad++;
    end
    check("idle_outputs", bad, 0);
    check("idle_state", dbg_state, 0);

    // asynchronous reset in the middle of a CALC pass
    @(posedge clk); #1;
    drive_cfg(cases[0]);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (30) @(posedge clk);
    #3;
    check("pre_rst_busy", busy, 1);
    check("pre_rst_pvalid", pvalid, 8'hFF);
    rstn = 1'b0;
    #1;
    check("rst_async_outputs",
          {pvalid, busy, done, ifm_read, wgt_read, ic_done, oc_done, tile_done, conv_done}, 0);
    check("rst_async_state", dbg_state, 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (pvalid != '0 || busy) bad++;
    end
    check("post_rst_residual", bad, 0);

    for (int i = 0; i < 6; i++) run_case(i, cases[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
